// File: rtl/biriscv_trace_retire_fifo.sv
// Dual-retire trace FIFO: captures up to two retired instructions per cycle in
// program order and replays them one per cycle; entries that do not fit are dropped.
module biriscv_trace_retire_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ret0_valid_i,
  input  logic [31:0]       ret0_pc_i,
  input  logic [31:0]       ret0_opcode_i,
  input  logic              ret1_valid_i,
  input  logic [31:0]       ret1_pc_i,
  input  logic [31:0]       ret1_opcode_i,
  output logic              valid_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       opcode_o,
  input  logic              accept_i,
  output logic [ADDR_W:0]   level_o,
  output logic              overflow_o,
  output logic [15:0]       drop_count_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic              valid_q, valid_d;
  logic              overflow_q, overflow_d;
  logic [15:0]       drop_q, drop_d;
  logic [63:0]       mem_q [DEPTH];

  logic              pop_s;
  logic [ADDR_W:0]   space_s;
  logic [1:0]        nvalid_s, npush_s, ndrop_s;
  logic [63:0]       first_s, second_s;
  logic              we0_s, we1_s;
  logic [ADDR_W-1:0] wr1_s;
  logic [16:0]       drop_sum_s;

  // Next-state: pop frees a slot before pushes claim space; slot 1 drops first.
  always_comb begin
    pop_s      = valid_q & accept_i;
    space_s    = DEPTH_C - count_q + (ADDR_W+1)'(pop_s);
    nvalid_s   = {1'b0, ret0_valid_i} + {1'b0, ret1_valid_i};
    if (space_s >= (ADDR_W+1)'(nvalid_s)) begin
      npush_s = nvalid_s;
    end else begin
      npush_s = space_s[1:0];
    end
    ndrop_s    = nvalid_s - npush_s;
    first_s    = ret0_valid_i ? {ret0_pc_i, ret0_opcode_i} : {ret1_pc_i, ret1_opcode_i};
    second_s   = {ret1_pc_i, ret1_opcode_i};
    wr1_s      = wr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    drop_sum_s = {1'b0, drop_q} + {15'd0, ndrop_s};
    if (flush_i) begin
      we0_s      = 1'b0;
      we1_s      = 1'b0;
      count_d    = '0;
      rd_d       = '0;
      wr_d       = '0;
      overflow_d = overflow_q;
      drop_d     = drop_q;
    end else begin
      we0_s      = (npush_s != 2'd0);
      we1_s      = (npush_s == 2'd2);
      count_d    = count_q + (ADDR_W+1)'(npush_s) - (ADDR_W+1)'(pop_s);
      rd_d       = rd_q + ADDR_W'(pop_s);
      wr_d       = wr_q + ADDR_W'(npush_s);
      overflow_d = overflow_q | (ndrop_s != 2'd0);
      drop_d     = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
    end
    valid_d = (count_d != '0);
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q    <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= 16'd0;
    end else begin
      count_q    <= count_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  // Entry storage; contents need no reset since valid_q gates the head.
  always_ff @(posedge clk_i) begin
    if (we0_s) begin
      mem_q[wr_q] <= first_s;
    end
    if (we1_s) begin
      mem_q[wr1_s] <= second_s;
    end
  end

  assign valid_o           = valid_q;
  assign {pc_o, opcode_o}  = valid_q ? mem_q[rd_q] : 64'd0;
  assign level_o           = count_q;
  assign overflow_o        = overflow_q;
  assign drop_count_o      = drop_q;

endmodule

// File: tb/tb_biriscv_trace_retire_fifo.sv
// Self-checking bench: directed vector table, reset/flush sequences, and random
// traffic against a queue-based reference model.
module tb_biriscv_trace_retire_fifo;
  localparam int DEPTH = 8;
  localparam logic [31:0] OPK = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst_n, flush;
  logic        r0v, r1v, acc;
  logic [31:0] r0pc, r0op, r1pc, r1op;
  logic        valid;
  logic [31:0] pc, opcode;
  logic [3:0]  level;
  logic        ovf;
  logic [15:0] drops;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] mq[$];
  bit          m_ovf;
  int          m_drop;

  typedef struct {
    bit          flush;
    bit          r0v;
    logic [31:0] r0pc;
    bit          r1v;
    logic [31:0] r1pc;
    bit          acc;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [3:0]  e_level;
    logic [15:0] e_drop;
    bit          e_ovf;
  } vec_t;
  vec_t tbl[$];

  biriscv_trace_retire_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .clk_i(clk), .rst_i(rst_n), .flush_i(flush),
    .ret0_valid_i(r0v), .ret0_pc_i(r0pc), .ret0_opcode_i(r0op),
    .ret1_valid_i(r1v), .ret1_pc_i(r1pc), .ret1_opcode_i(r1op),
    .valid_o(valid), .pc_o(pc), .opcode_o(opcode), .accept_i(acc),
    .level_o(level), .overflow_o(ovf), .drop_count_o(drops)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic set_in(input bit f, input bit v0, input logic [31:0] p0,
                        input bit v1, input logic [31:0] p1, input bit a);
    flush = f; r0v = v0; r0pc = p0; r0op = p0 ^ OPK;
    r1v = v1; r1pc = p1; r1op = p1 ^ OPK; acc = a;
  endtask

  task automatic push_or_drop(input logic [63:0] e);
    if (mq.size() < DEPTH) mq.push_back(e);
    else begin
      m_ovf = 1'b1;
      if (m_drop < 65535) m_drop++;
    end
  endtask

  // Reference behaviour for one clock edge, from the inputs the DUT saw.
  task automatic model_edge();
    if (!rst_n) begin
      mq.delete(); m_ovf = 1'b0; m_drop = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      if (mq.size() > 0 && acc) void'(mq.pop_front());
      if (r0v) push_or_drop({r0pc, r0op});
      if (r1v) push_or_drop({r1pc, r1op});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [63:0] head;
    head = (mq.size() > 0) ? mq[0] : 64'd0;
    chk({tag, ".valid"},  {31'd0, valid}, {31'd0, mq.size() > 0});
    chk({tag, ".pc"},     pc, head[63:32]);
    chk({tag, ".opcode"}, opcode, head[31:0]);
    chk({tag, ".level"},  {28'd0, level}, 32'(mq.size()));
    chk({tag, ".ovf"},    {31'd0, ovf}, {31'd0, m_ovf});
    chk({tag, ".drops"},  {16'd0, drops}, 32'(m_drop));
  endtask

  task automatic addv(input bit f, input bit v0, input logic [31:0] p0, input bit v1,
                      input logic [31:0] p1, input bit a, input bit ev, input logic [31:0] ep,
                      input logic [3:0] el, input logic [15:0] ed, input bit eo);
    vec_t v;
    v = '{f, v0, p0, v1, p1, a, ev, ep, el, ed, eo};
    tbl.push_back(v);
  endtask

  initial begin
    m_ovf = 1'b0; m_drop = 0;
    // Reset with arbitrary, busy inputs.
    rst_n = 1'b0;
    set_in(1'b0, 1'b1, 32'h1234_5678, 1'b1, 32'h9ABC_DEF0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", {31'd0, valid}, 32'd0);
    chk("rst.pc", pc, 32'd0);
    chk("rst.opcode", opcode, 32'd0);
    chk("rst.level", {28'd0, level}, 32'd0);
    chk("rst.drops", {16'd0, drops}, 32'd0);
    chk("rst.ovf", {31'd0, ovf}, 32'd0);
    mq.delete();
    set_in(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    rst_n = 1'b1;

    // Dual retire with free-running consumer.
    addv(0, 1, 32'h8000_0000, 1, 32'h8000_0004, 1, 1, 32'h8000_0000, 4'd2, 16'd0, 0);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h8000_0004, 4'd1, 16'd0, 0);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 4'd0, 16'd0, 0);
    // Fill to full, then overflow by two.
    addv(0, 1, 32'h10, 1, 32'h14, 0, 1, 32'h10, 4'd2, 16'd0, 0);
    addv(0, 1, 32'h18, 1, 32'h1C, 0, 1, 32'h10, 4'd4, 16'd0, 0);
    addv(0, 1, 32'h20, 1, 32'h24, 0, 1, 32'h10, 4'd6, 16'd0, 0);
    addv(0, 1, 32'h28, 1, 32'h2C, 0, 1, 32'h10, 4'd8, 16'd0, 0);
    addv(0, 1, 32'h30, 1, 32'h34, 0, 1, 32'h10, 4'd8, 16'd2, 1);
    // Full with pop: slot 0 fits, slot 1 dropped.
    addv(0, 1, 32'h100, 1, 32'h104, 1, 1, 32'h14, 4'd8, 16'd3, 1);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h18, 4'd7, 16'd3, 1);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h1C, 4'd6, 16'd3, 1);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h20, 4'd5, 16'd3, 1);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h24, 4'd4, 16'd3, 1);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h28, 4'd3, 16'd3, 1);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h2C, 4'd2, 16'd3, 1);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 1, 32'h100, 4'd1, 16'd3, 1);
    addv(0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 4'd0, 16'd3, 1);
    // Slot 1 alone, then flush with a same-cycle dual retire.
    addv(0, 0, 32'h0, 1, 32'h200, 0, 1, 32'h200, 4'd1, 16'd3, 1);
    addv(1, 1, 32'h300, 1, 32'h304, 0, 0, 32'h0, 4'd0, 16'd3, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].flush, tbl[i].r0v, tbl[i].r0pc, tbl[i].r1v, tbl[i].r1pc, tbl[i].acc);
      tick();
      chk($sformatf("vec%0d.valid", i), {31'd0, valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d.pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d.opcode", i), opcode, tbl[i].e_valid ? (tbl[i].e_pc ^ OPK) : 32'd0);
      chk($sformatf("vec%0d.level", i), {28'd0, level}, {28'd0, tbl[i].e_level});
      chk($sformatf("vec%0d.drops", i), {16'd0, drops}, {16'd0, tbl[i].e_drop});
      chk($sformatf("vec%0d.ovf", i), {31'd0, ovf}, {31'd0, tbl[i].e_ovf});
    end

    // Asynchronous reset in the middle of a drain.
    set_in(0, 1, 32'h400, 1, 32'h404, 0); tick();
    set_in(0, 1, 32'h408, 0, 32'h0, 0);   tick();
    chk("mid.level3", {28'd0, level}, 32'd3);
    set_in(0, 0, 32'h0, 0, 32'h0, 1);     tick();
    chk("mid.pc", pc, 32'h404);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, valid}, 32'd0);
    chk("arst.pc", pc, 32'd0);
    chk("arst.level", {28'd0, level}, 32'd0);
    chk("arst.drops", {16'd0, drops}, 32'd0);
    chk("arst.ovf", {31'd0, ovf}, 32'd0);
    tick();
    rst_n = 1'b1;
    set_in(0, 1, 32'h300, 0, 32'h0, 1); tick();
    chk("post.valid", {31'd0, valid}, 32'd1);
    chk("post.pc", pc, 32'h300);
    set_in(0, 0, 32'h0, 0, 32'h0, 1);   tick();
    check_model("post.drain");

    // Random traffic against the reference model, varying consumer pressure.
    for (int i = 0; i < 3000; i++) begin
      int accp;
      accp = (i / 250) % 4;
      set_in($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, $urandom,
             $urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 3) < accp);
      r0op = $urandom; r1op = $urandom;
      tick();
      check_model($sformatf("rnd%0d", i));
    end

    // Drop counter saturation with a stalled consumer.
    set_in(0, 1, 32'hC000_0000, 1, 32'hC000_0004, 0);
    for (int i = 0; i < 32800; i++) tick();
    check_model("sat");
    chk("sat.ffff", {16'd0, drops}, 32'h0000_FFFF);
    tick();
    chk("sat.hold", {16'd0, drops}, 32'h0000_FFFF);
    set_in(1, 1, 32'h0, 1, 32'h4, 0); tick();
    check_model("sat.flush");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
